registrador_universal: RTL and testbench
========================================

REGISTRADOR_UNIVERSAL -- requirements
Module: registrador_universal

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning register width in bits; legal range 2..32.
REQ-002 The block SHALL expose the following ports, one per line:
- Clk  input  1  rising-edge clock; the only clock.
- Rst  input  1  asynchronous reset, active-high.
- En  input  1  operation enable; 0 = hold all state.
- Modo  input  3  operation select, see REQ-006.
- D  input  WIDTH  parallel load data.
- Sin  input  1  serial input bit for shift modes.
- Q  output  WIDTH  register contents.
- Qn  output  WIDTH  bitwise complement of Q.
- SoutE  output  1  Q[WIDTH-1], the left/MSB serial out.
- SoutD  output  1  Q[0], the right/LSB serial out.
- Cout  output  1  registered carry/borrow flag for the count modes.
REQ-003 Clk SHALL be the only clock; Rst SHALL be asynchronous and active-high.

Function
REQ-004 Q and Cout SHALL be the only state elements; they SHALL update only on the rising edge of Clk, except under Rst.
REQ-005 Qn, SoutE and SoutD SHALL be purely combinational from Q, with zero cycle latency.
REQ-006 When En=1, the register SHALL perform the operation selected by Modo at the next rising edge:
- 000 hold: Q unchanged.
- 001 load: Q <= D.
- 010 shift left: Q <= {Q[WIDTH-2:0], Sin}.
- 011 shift right: Q <= {Sin, Q[WIDTH-1:1]}.
- 100 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- 101 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
- 110 count up: Q <= Q+1, modulo 2^WIDTH.
- 111 count down: Q <= Q-1, modulo 2^WIDTH.
REQ-007 When En=0, Q and Cout SHALL hold regardless of Modo, D and Sin.
REQ-008 In mode 110 with En=1, Cout SHALL be set to 1 if Q was all ones before the edge (wrap to 0), else 0.
REQ-009 In mode 111 with En=1, Cout SHALL be set to 1 if Q was 0 before the edge (wrap to all ones), else 0.
REQ-010 In modes 000–101 with En=1, Cout SHALL be cleared to 0 on the edge.
REQ-011 All arithmetic SHALL be unsigned at WIDTH bits; no bit beyond WIDTH is stored except Cout.
REQ-012 Modo, D, Sin and En SHALL be sampled only at the rising edge; changes between edges SHALL have no effect on Q or Cout.
REQ-013 Each operation SHALL use only pre-edge Q (no intra-cycle chaining); a shift of one position per enabled edge.

Reset
REQ-014 While Rst=1, Q SHALL be 0, Cout 0, Qn all ones, SoutE 0, SoutD 0, independent of Clk.
REQ-015 Rst assertion SHALL take effect immediately (asynchronously), including mid-operation; any edge coincident with Rst=1 SHALL be ignored.
REQ-016 After Rst deasserts, the first rising edge with En=1 SHALL perform the selected operation from Q=0.

Verification
REQ-017 Load/complement: WIDTH=8, load D=8'hA5 -> next cycle Q=8'hA5, Qn=8'h5A, SoutE=1, SoutD=1, Cout=0.
REQ-018 Shift: Q=8'h81, mode 010 with Sin=0 -> Q=8'h02, then mode 011 with Sin=1 -> Q=8'h81.
REQ-019 Rotate: Q=8'h81, mode 100 -> Q=8'h03, then mode 101 twice -> Q=8'hC0.
REQ-020 Count wrap: Q=8'hFE, mode 110 for 2 edges -> Q=8'hFF with Cout=0, then Q=8'h00 with Cout=1; then mode 111 -> Q=8'hFF with Cout=1.
REQ-021 Enable/hold: Q=8'h3C, En=0 with mode 001 and D=8'h00 for 3 edges -> Q stays 8'h3C and Cout unchanged; mode 000 with En=1 -> Q=8'h3C, Cout=0.
REQ-022 Async reset: assert Rst between edges during a count sequence -> Q=0, Cout=0 before the next edge; release -> counting resumes from 0 (Q=1 after the first enabled 110 edge).

Source files
------------

// File: rtl/registrador_universal.sv
// Universal register: hold, load, shift, rotate and count.
// Cout flags a wrap in the count modes and is cleared otherwise.
module registrador_universal #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [2:0]       Modo,
    input  logic [WIDTH-1:0] D,
    input  logic             Sin,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             SoutE,
    output logic             SoutD,
    output logic             Cout
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_UP   = 3'b110;
    localparam logic [2:0] M_DOWN = 3'b111;

    logic [WIDTH-1:0] q_nxt;
    logic             c_nxt;

    // Next value of Q and Cout, computed from pre-edge Q only
    always_comb begin
        q_nxt = Q;
        c_nxt = 1'b0;
        unique case (Modo)
            M_HOLD: q_nxt = Q;
            M_LOAD: q_nxt = D;
            M_SHL:  q_nxt = {Q[WIDTH-2:0], Sin};
            M_SHR:  q_nxt = {Sin, Q[WIDTH-1:1]};
            M_ROL:  q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
            M_ROR:  q_nxt = {Q[0], Q[WIDTH-1:1]};
            M_UP: begin
                q_nxt = Q + ONE;
                c_nxt = &Q;
            end
            M_DOWN: begin
                q_nxt = Q - ONE;
                c_nxt = ~|Q;
            end
            default: q_nxt = Q;
        endcase
    end

    // State register; disabled edges leave both Q and Cout untouched
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Q    <= '0;
            Cout <= 1'b0;
        end else if (En) begin
            Q    <= q_nxt;
            Cout <= c_nxt;
        end
    end

    assign Qn    = ~Q;
    assign SoutE = Q[WIDTH-1];
    assign SoutD = Q[0];

endmodule

// File: tb/tb_registrador_universal.sv
// Directed bench for registrador_universal (WIDTH=8).
// Expected Q/Cout are queued at drive time and checked after the edge.
module tb_registrador_universal;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic [2:0] Modo;
    logic [7:0] D;
    logic       Sin;
    logic [7:0] Q;
    logic [7:0] Qn;
    logic       SoutE;
    logic       SoutD;
    logic       Cout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] q;
        logic       c;
        string      tag;
    } exp_t;

    exp_t sb[$];

    registrador_universal #(.WIDTH(8)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .En   (En),
        .Modo (Modo),
        .D    (D),
        .Sin  (Sin),
        .Q    (Q),
        .Qn   (Qn),
        .SoutE(SoutE),
        .SoutD(SoutD),
        .Cout (Cout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cmp(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Compare every output against one expected (Q, Cout) pair
    task automatic check_all(input string tag, input logic [7:0] eq,
                             input logic ec);
        cmp({tag, ".q"}, Q, eq);
        cmp({tag, ".qn"}, Qn, ~eq);
        cmp({tag, ".soute"}, {7'd0, SoutE}, {7'd0, eq[7]});
        cmp({tag, ".soutd"}, {7'd0, SoutD}, {7'd0, eq[0]});
        cmp({tag, ".cout"}, {7'd0, Cout}, {7'd0, ec});
    endtask

    task automatic pop_check();
        exp_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_bad++;
            $error("FAIL sb_empty: observed %0d expected >0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_all(e.tag, e.q, e.c);
        end
    endtask

    // Drive one enabled/disabled edge and queue its expected result
    task automatic step(input logic en_i, input logic [2:0] m,
                        input logic [7:0] d_i, input logic s,
                        input logic [7:0] eq, input logic ec,
                        input string tag);
        exp_t e;
        @(negedge Clk);
        En   = en_i;
        Modo = m;
        D    = d_i;
        Sin  = s;
        e.q = eq;
        e.c = ec;
        e.tag = tag;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst  = 1'b1;
        En   = 1'b1;
        Modo = 3'b001;
        D    = 8'hFF;
        Sin  = 1'b1;
        #2;
        check_all("reset", 8'h00, 1'b0);
        // Edges during reset must be ignored
        @(posedge Clk);
        #1;
        check_all("reset_edge", 8'h00, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;

        step(1, 3'b001, 8'hA5, 0, 8'hA5, 0, "load_a5");
        step(1, 3'b001, 8'h81, 0, 8'h81, 0, "load_81");
        step(1, 3'b010, 8'h00, 0, 8'h02, 0, "shl");
        step(1, 3'b011, 8'h00, 1, 8'h81, 0, "shr");
        step(1, 3'b100, 8'h00, 0, 8'h03, 0, "rol");
        step(1, 3'b101, 8'h00, 0, 8'h81, 0, "ror1");
        step(1, 3'b101, 8'h00, 0, 8'hC0, 0, "ror2");

        step(1, 3'b001, 8'hFE, 0, 8'hFE, 0, "load_fe");
        step(1, 3'b110, 8'h00, 0, 8'hFF, 0, "up_ff");
        step(1, 3'b110, 8'h00, 0, 8'h00, 1, "up_wrap");
        step(1, 3'b111, 8'h00, 0, 8'hFF, 1, "down_wrap");
        step(0, 3'b001, 8'h00, 1, 8'hFF, 1, "hold_c1a");
        step(0, 3'b110, 8'h12, 0, 8'hFF, 1, "hold_c1b");
        step(1, 3'b000, 8'h55, 1, 8'hFF, 0, "hold_clr");

        step(1, 3'b001, 8'h05, 0, 8'h05, 0, "load_05");
        step(1, 3'b111, 8'h00, 0, 8'h04, 0, "down_4");
        step(1, 3'b110, 8'h00, 0, 8'h05, 0, "up_5");

        step(1, 3'b001, 8'h3C, 0, 8'h3C, 0, "load_3c");
        step(0, 3'b001, 8'h00, 0, 8'h3C, 0, "dis1");
        step(0, 3'b001, 8'h00, 0, 8'h3C, 0, "dis2");
        step(0, 3'b001, 8'h00, 0, 8'h3C, 0, "dis3");
        step(1, 3'b000, 8'h00, 0, 8'h3C, 0, "hold_en");

        // Inputs that change only between edges have no effect
        @(negedge Clk);
        En   = 1'b1;
        Modo = 3'b001;
        D    = 8'hAA;
        #2;
        En = 1'b0;
        @(posedge Clk);
        #1;
        check_all("glitch", 8'h3C, 1'b0);

        // Async reset mid-count
        step(1, 3'b001, 8'h10, 0, 8'h10, 0, "load_10");
        step(1, 3'b110, 8'h00, 0, 8'h11, 0, "up_11");
        @(negedge Clk);
        En   = 1'b1;
        Modo = 3'b110;
        #1;
        Rst = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 1'b0);
        #1;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        check_all("after_rst", 8'h01, 1'b0);
        step(1, 3'b110, 8'h00, 0, 8'h02, 0, "after_rst2");

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL sb_left: observed %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
